overlap_framer: RTL and testbench
=================================

# overlap_framer

Encoder-side counterpart of the AAC overlap/add stage: segments a continuous PCM sample stream into 50%-overlapped analysis frames of 2·halfWindowSize samples for windowing and MDCT. Each frame is the previous frame's second half (held in an internal history buffer) followed by halfWindowSize fresh samples. Each frame is tagged with the shared sequence-position code so the downstream stages and the decoder's overlap/add agree on first, middle and last frames.

## Interface
- halfWindowSize, 512, samples per half window (N); power of two, ≥4
- wordLength, 16, bits per PCM sample
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  input sample accepted when in_valid && in_ready
- in_sample  in  wordLength  PCM input sample
- in_last  in  1  marks the final sample of the stream; qualified by the in_valid && in_ready handshake
- out_valid  out  1  output sample valid (registered)
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_sample  out  wordLength  framed output sample
- out_frame_start  out  1  high on sample 0 of a frame
- out_frame_end  out  1  high on sample 2N-1 of a frame
- out_seq_pos  out  2  0 = middle, 1 = first, 2 = last; constant across a frame

## Operation
- States: IDLE, HIST, FRESH, PAD, TAIL_HIST, TAIL_ZERO. Sample counter cnt covers 0..N-1. first_flag is set by reset.
- IDLE: in_ready=0. If in_valid=1 → HIST, cnt=0. The waiting sample is not consumed.
- HIST: emits hist[cnt], or 0 while first_flag=1. At cnt=N-1 → FRESH, cnt=0.
- FRESH: in_ready = !out_valid || out_ready. Each accepted sample is loaded into the output register and written to hist[cnt]. This cannot conflict with reads, because HIST has already read every location of this frame.
  - Accepted with in_last=1 and cnt<N-1 → PAD.
  - Accepted with in_last=1 and cnt=N-1 → TAIL_HIST.
  - Accepted at cnt=N-1 with in_last=0 → HIST, and first_flag clears.
- PAD: in_ready=0. Emits 0 and writes 0 to hist[cnt] until cnt=N-1, then → TAIL_HIST.
- TAIL_HIST: emits hist[cnt], then → TAIL_ZERO.
- TAIL_ZERO: emits N zeros, then → IDLE and first_flag sets.
- Frame tags:
  - out_seq_pos=1 for the frame with first_flag=1, even if in_last falls inside it.
  - out_seq_pos=2 for the TAIL frame.
  - out_seq_pos=0 otherwise.
- Framing flags: out_frame_start on HIST/TAIL_HIST cnt=0; out_frame_end on FRESH/PAD/TAIL_ZERO cnt=N-1.
- No arithmetic on samples; data passes bit-exact. cnt is $clog2(N) bits, and its wrap from N-1 to 0 coincides with each state change.

## Timing
- Output register load rule: loads when !out_valid || out_ready; otherwise all out_* hold stable. This also holds while in_valid=0 in FRESH, when out_valid drops after the current sample is taken.
- Reset values: out_valid=0, out_sample=0, out_frame_start=0, out_frame_end=0, out_seq_pos=0, in_ready=0, state=IDLE, cnt=0, first_flag=1. History RAM contents are not cleared.
- Latency: in_valid rising in IDLE gives out_valid=1 two cycles later, carrying the first history sample.
- Throughput: with out_ready=1 and in_valid=1, one sample/cycle, so one frame every 2N cycles with no bubbles between frames.
- in_ready depends combinationally on out_ready; there is no combinational path from in_valid to out_valid.
- rst mid-frame: the partial frame is abandoned. The next frame after reset is tagged first with a zero history half.

## Structure
- overlap_defs.vh: SEQ_MIDDLE=0, SEQ_FIRST=1, SEQ_LAST=2 (shared with the decoder's overlap/add), plus the state encodings.
- Sub-module history_buffer: N×wordLength storage with one synchronous write port and one asynchronous read port addressed by cnt.
- FSM, counter and output register live in overlap_framer.

## Test plan
- N=4, stream 1..8 then in_last on 8, out_ready=1 → outputs:
  - 0,0,0,0,1,2,3,4 (seq 1)
  - 1,2,3,4,5,6,7,8 (seq 0)
  - 5,6,7,8,0,0,0,0 (seq 2)
  - start/end flags on sample 0 and sample 7 of each frame.
- N=4, in_last on sample 6 → second frame is 1,2,3,4,5,6,0,0 → tail frame 5,6,0,0,0,0,0,0 (seq 2) → IDLE.
- Random out_ready (50%) and in_valid gaps → output sequence identical to the stalled-free run; out_* stable whenever out_valid && !out_ready.
- rst asserted in FRESH at cnt=2 → next cycle all outputs 0; restart with 9..12 gives frame 0,0,0,0,9,10,11,12 tagged seq 1.
- N=512, 2048 ramp samples with continuous handshake → 4 full frames plus tail frame, no idle cycles between frames; frame k first half equals frame k-1 second half.

Source files
------------

// File: rtl/overlap_framer_pkg.sv
// Shared definitions for the overlap framer.
// - SEQ_* codes: frame sequence-position tags, shared with the decoder's overlap/add stage.
// - state_e: framer FSM state encoding.
// - seq_code(): maps the first/tail frame condition onto a sequence-position code.
package overlap_framer_pkg;

    localparam logic [1:0] SEQ_MIDDLE = 2'd0;
    localparam logic [1:0] SEQ_FIRST  = 2'd1;
    localparam logic [1:0] SEQ_LAST   = 2'd2;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StHist     = 3'd1,
        StFresh    = 3'd2,
        StPad      = 3'd3,
        StTailHist = 3'd4,
        StTailZero = 3'd5
    } state_e;

    // The tail tag takes priority over the first tag.
    function automatic logic [1:0] seq_code(input logic first_flag, input logic tail);
        if (tail) begin
            return SEQ_LAST;
        end else if (first_flag) begin
            return SEQ_FIRST;
        end
        return SEQ_MIDDLE;
    endfunction

endpackage

// File: rtl/overlap_framer_history_buffer.sv
// Second-half history store for the overlap framer.
// Ports:
//   clk   - clock, write on rising edge
//   we    - write enable
//   addr  - shared read/write address (the framer's sample counter)
//   wdata - write data
//   rdata - asynchronous read data at addr
// Contents are not reset; the framer masks them while a first frame is being built.
module overlap_framer_history_buffer #(
    parameter int unsigned Depth = 512,
    parameter int unsigned Width = 16,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] addr,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/overlap_framer.sv
// Overlap framer: slices a PCM stream into 50%-overlapped frames of 2*halfWindowSize samples.
// Each frame is the previous frame's fresh half (replayed from history) followed by
// halfWindowSize new samples, tagged with a sequence-position code (first/middle/last).
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   in_valid/in_ready/in_sample/in_last - input sample stream (in_last marks final sample)
//   out_valid/out_ready/out_sample    - registered framed output stream
//   out_frame_start/out_frame_end     - first/last sample of each 2N-sample frame
//   out_seq_pos                       - 0 middle, 1 first, 2 last; constant across a frame
module overlap_framer
    import overlap_framer_pkg::*;
#(
    parameter int unsigned halfWindowSize = 512,
    parameter int unsigned wordLength     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [wordLength-1:0] in_sample,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [wordLength-1:0] out_sample,
    output logic                  out_frame_start,
    output logic                  out_frame_end,
    output logic [1:0]            out_seq_pos
);

    localparam int unsigned CntW = $clog2(halfWindowSize);
    localparam logic [CntW-1:0] CntMax = CntW'(halfWindowSize - 1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  first_q, first_d;

    logic                  load;
    logic                  cnt_last;
    logic                  emit;
    logic [wordLength-1:0] emit_sample;
    logic                  emit_start;
    logic                  emit_end;
    logic                  emit_tail;

    logic                  hist_we;
    logic [wordLength-1:0] hist_wdata;
    logic [wordLength-1:0] hist_rdata;

    logic                  out_valid_d;
    logic [wordLength-1:0] out_sample_d;
    logic                  out_frame_start_d;
    logic                  out_frame_end_d;
    logic [1:0]            out_seq_pos_d;

    overlap_framer_history_buffer #(
        .Depth (halfWindowSize),
        .Width (wordLength)
    ) u_hist (
        .clk   (clk),
        .we    (hist_we),
        .addr  (cnt_q),
        .wdata (hist_wdata),
        .rdata (hist_rdata)
    );

    always_comb begin
        load     = !out_valid || out_ready;
        cnt_last = (cnt_q == CntMax);
        in_ready = (state_q == StFresh) && load;

        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        emit        = 1'b0;
        emit_sample = '0;
        emit_start  = 1'b0;
        emit_end    = 1'b0;
        emit_tail   = 1'b0;
        hist_we     = 1'b0;
        hist_wdata  = in_sample;

        unique case (state_q)
            StIdle: begin
                // The waiting sample stays on the bus until FRESH.
                if (in_valid) begin
                    state_d = StHist;
                    cnt_d   = '0;
                end
            end
            StHist: begin
                if (load) begin
                    emit        = 1'b1;
                    emit_sample = first_q ? '0 : hist_rdata;
                    emit_start  = (cnt_q == '0);
                    if (cnt_last) state_d = StFresh;
                end
            end
            StFresh: begin
                // HIST has already read every slot of this frame, so overwriting is safe.
                if (in_valid && in_ready) begin
                    emit        = 1'b1;
                    emit_sample = in_sample;
                    emit_end    = cnt_last;
                    hist_we     = 1'b1;
                    if (in_last) begin
                        state_d = cnt_last ? StTailHist : StPad;
                    end else if (cnt_last) begin
                        state_d = StHist;
                        first_d = 1'b0;
                    end
                end
            end
            StPad: begin
                if (load) begin
                    emit        = 1'b1;
                    emit_end    = cnt_last;
                    hist_we     = 1'b1;
                    hist_wdata  = '0;
                    if (cnt_last) state_d = StTailHist;
                end
            end
            StTailHist: begin
                if (load) begin
                    emit        = 1'b1;
                    emit_sample = hist_rdata;
                    emit_start  = (cnt_q == '0);
                    emit_tail   = 1'b1;
                    if (cnt_last) state_d = StTailZero;
                end
            end
            StTailZero: begin
                if (load) begin
                    emit      = 1'b1;
                    emit_end  = cnt_last;
                    emit_tail = 1'b1;
                    if (cnt_last) begin
                        state_d = StIdle;
                        first_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // N is a power of two, so the natural wrap lands on 0 with each state change.
        if (emit) cnt_d = cnt_q + CntW'(1);

        out_valid_d       = out_valid;
        out_sample_d      = out_sample;
        out_frame_start_d = out_frame_start;
        out_frame_end_d   = out_frame_end;
        out_seq_pos_d     = out_seq_pos;
        if (emit) begin
            out_valid_d       = 1'b1;
            out_sample_d      = emit_sample;
            out_frame_start_d = emit_start;
            out_frame_end_d   = emit_end;
            out_seq_pos_d     = seq_code(first_q, emit_tail);
        end else if (load) begin
            // Slot consumed with nothing new: drop valid, keep the rest stable.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            first_q         <= 1'b1;
            out_valid       <= 1'b0;
            out_sample      <= '0;
            out_frame_start <= 1'b0;
            out_frame_end   <= 1'b0;
            out_seq_pos     <= SEQ_MIDDLE;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            first_q         <= first_d;
            out_valid       <= out_valid_d;
            out_sample      <= out_sample_d;
            out_frame_start <= out_frame_start_d;
            out_frame_end   <= out_frame_end_d;
            out_seq_pos     <= out_seq_pos_d;
        end
    end

endmodule

// File: tb/tb_overlap_framer.sv
// Self-checking bench for overlap_framer: an N=4 instance for the short scenarios and an
// N=512 instance for the long ramp. Expected frames are built from the input stream by an
// independent frame model and queued, then popped as output handshakes occur.
module tb_overlap_framer;

    typedef struct packed {
        logic [15:0] sample;
        logic        fstart;
        logic        fend;
        logic [1:0]  seq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_s, rst_b;
    logic        sel;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in_sample;

    logic        in_ready_s, out_valid_s, start_s, end_s;
    logic [15:0] sample_s;
    logic [1:0]  seq_s;
    logic        in_ready_b, out_valid_b, start_b, end_b;
    logic [15:0] sample_b;
    logic [1:0]  seq_b;

    logic        in_ready_m, out_valid_m, start_m, end_m;
    logic [15:0] sample_m;
    logic [1:0]  seq_m;

    int          tests = 0;
    int          failed = 0;
    logic [15:0] stim_q[$];
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    overlap_framer #(.halfWindowSize(4), .wordLength(16)) dut_s (
        .clk(clk), .rst(rst_s), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_sample(in_sample), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_sample(sample_s), .out_frame_start(start_s),
        .out_frame_end(end_s), .out_seq_pos(seq_s)
    );

    overlap_framer #(.halfWindowSize(512), .wordLength(16)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_sample(in_sample), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sample(sample_b), .out_frame_start(start_b),
        .out_frame_end(end_b), .out_seq_pos(seq_b)
    );

    assign in_ready_m  = sel ? in_ready_b  : in_ready_s;
    assign out_valid_m = sel ? out_valid_b : out_valid_s;
    assign sample_m    = sel ? sample_b    : sample_s;
    assign start_m     = sel ? start_b     : start_s;
    assign end_m       = sel ? end_b       : end_s;
    assign seq_m       = sel ? seq_b       : seq_s;

    // Frame model: previous fresh half (zeros for the first frame) + next N samples,
    // zero-padded; the frame holding the final sample is followed by a tail frame.
    task automatic push_expected(input int n);
        logic [15:0] prev [512];
        logic [15:0] chunk [512];
        int   pos, len;
        bit   first, done;
        exp_t e;
        len = stim_q.size(); pos = 0; first = 1; done = 0;
        for (int i = 0; i < n; i++) prev[i] = '0;
        while (!done) begin
            for (int i = 0; i < n; i++) begin
                if (pos < len) begin chunk[i] = stim_q[pos]; pos++; end
                else chunk[i] = '0;
            end
            done = (pos >= len);
            for (int i = 0; i < 2 * n; i++) begin
                e.sample = (i < n) ? prev[i] : chunk[i - n];
                e.fstart = (i == 0);
                e.fend   = (i == 2 * n - 1);
                e.seq    = first ? 2'd1 : 2'd0;
                exp_q.push_back(e);
            end
            if (done) begin
                for (int i = 0; i < 2 * n; i++) begin
                    e.sample = (i < n) ? chunk[i] : 16'd0;
                    e.fstart = (i == 0);
                    e.fend   = (i == 2 * n - 1);
                    e.seq    = 2'd2;
                    exp_q.push_back(e);
                end
            end else begin
                for (int i = 0; i < n; i++) prev[i] = chunk[i];
                first = 0;
            end
        end
    endtask

    // Streams stim_q into the selected DUT and checks every accepted output against exp_q.
    task automatic run_stream(input int n, input int gap_pct, input int stall_pct,
                              input bit strict, input string name);
        int   idx, len, limit, first_in, first_out, bubbles, nout;
        bit   held_v, fire_in, fire_out;
        exp_t held, got, want;
        len = stim_q.size();
        push_expected(n);
        limit = 8 * exp_q.size() + 200;
        idx = 0; first_in = -1; first_out = -1; bubbles = 0; held_v = 0; nout = 0;
        held = '0;
        for (int cyc = 0; cyc < limit && exp_q.size() != 0; cyc++) begin
            if (idx < len && $urandom_range(99) >= gap_pct) begin
                in_valid  = 1'b1;
                in_sample = stim_q[idx];
                in_last   = (idx == len - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            #1;
            got = '{sample: sample_m, fstart: start_m, fend: end_m, seq: seq_m};
            if (held_v) begin
                tests++;
                if (got !== held || out_valid_m !== 1'b1) begin
                    failed++;
                    $display("FAIL %s stall_hold: got %h/%b/%b/%0d v=%b, required %h/%b/%b/%0d v=1",
                             name, got.sample, got.fstart, got.fend, got.seq, out_valid_m,
                             held.sample, held.fstart, held.fend, held.seq);
                end
            end
            fire_in  = in_valid && in_ready_m;
            fire_out = out_valid_m && out_ready;
            if (in_valid && first_in < 0) first_in = cyc;
            if (out_valid_m && first_out < 0) first_out = cyc;
            if (first_out >= 0 && !out_valid_m) bubbles++;
            if (fire_out) begin
                want = exp_q.pop_front();
                tests++;
                if (got !== want) begin
                    failed++;
                    $display("FAIL %s out[%0d]: got %h/%b/%b/%0d, required %h/%b/%b/%0d",
                             name, nout, got.sample, got.fstart, got.fend, got.seq,
                             want.sample, want.fstart, want.fend, want.seq);
                end
                nout++;
            end
            held_v = out_valid_m && !out_ready;
            held   = got;
            @(posedge clk); #1;
            if (fire_in) idx++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL %s timeout: %0d outputs outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (idx != len) begin
            failed++;
            $display("FAIL %s inputs_taken: got %0d, required %0d", name, idx, len);
        end
        if (strict) begin
            tests++;
            if (first_out - first_in != 2) begin
                failed++;
                $display("FAIL %s latency: got %0d, required 2", name, first_out - first_in);
            end
            tests++;
            if (bubbles != 0) begin
                failed++;
                $display("FAIL %s bubbles: got %0d, required 0", name, bubbles);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid_m !== 1'b0) begin
            failed++;
            $display("FAIL %s idle_after: out_valid got %b, required 0", name, out_valid_m);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_s = 1'b1; rst_b = 1'b1;
        in_valid = 1'b1; in_sample = 16'hbeef; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests += 6;
        if (out_valid_s !== 1'b0) begin failed++; $display("FAIL reset out_valid: got %b, required 0", out_valid_s); end
        if (sample_s !== 16'd0) begin failed++; $display("FAIL reset out_sample: got %h, required 0", sample_s); end
        if (start_s !== 1'b0) begin failed++; $display("FAIL reset frame_start: got %b, required 0", start_s); end
        if (end_s !== 1'b0) begin failed++; $display("FAIL reset frame_end: got %b, required 0", end_s); end
        if (seq_s !== 2'd0) begin failed++; $display("FAIL reset seq_pos: got %0d, required 0", seq_s); end
        if (in_ready_s !== 1'b0) begin failed++; $display("FAIL reset in_ready: got %b, required 0", in_ready_s); end
        in_valid = 1'b0;
        rst_s = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (in_ready_s !== 1'b0 || out_valid_s !== 1'b0) begin
            failed++;
            $display("FAIL reset idle: in_ready=%b out_valid=%b, required 0/0", in_ready_s, out_valid_s);
        end
    endtask

    task automatic test_basic();
        stim_q.delete();
        for (int i = 1; i <= 8; i++) stim_q.push_back(16'(i));
        run_stream(4, 0, 0, 1'b1, "basic");
    endtask

    task automatic test_pad();
        stim_q.delete();
        for (int i = 1; i <= 6; i++) stim_q.push_back(16'(i));
        run_stream(4, 0, 0, 1'b1, "pad");
    endtask

    task automatic test_random_stall();
        stim_q.delete();
        for (int i = 1; i <= 13; i++) stim_q.push_back(16'(16'h100 + i));
        run_stream(4, 30, 50, 1'b0, "random");
    endtask

    task automatic test_reset_midframe();
        int  acc;
        bit  fire;
        acc = 0;
        in_valid = 1'b1; in_sample = 16'd1; in_last = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 50 && acc < 2; c++) begin
            #1;
            fire = in_valid && in_ready_s;
            @(posedge clk); #1;
            if (fire) begin acc++; in_sample = 16'(acc + 1); end
        end
        tests++;
        if (acc != 2) begin
            failed++;
            $display("FAIL midreset accepted: got %0d, required 2", acc);
        end
        in_valid = 1'b0;
        rst_s = 1'b1;
        @(posedge clk); #1;
        rst_s = 1'b0;
        tests++;
        if ({out_valid_s, sample_s, start_s, end_s, seq_s, in_ready_s} !== 22'd0) begin
            failed++;
            $display("FAIL midreset outputs: got v=%b d=%h s=%b e=%b q=%0d r=%b, required all 0",
                     out_valid_s, sample_s, start_s, end_s, seq_s, in_ready_s);
        end
        stim_q.delete();
        for (int i = 9; i <= 12; i++) stim_q.push_back(16'(i));
        run_stream(4, 0, 0, 1'b1, "midreset_restart");
    endtask

    task automatic test_long();
        rst_s = 1'b1; rst_b = 1'b1; sel = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        stim_q.delete();
        for (int i = 1; i <= 2048; i++) stim_q.push_back(16'(i));
        run_stream(512, 0, 0, 1'b1, "long");
    endtask

    initial begin
        rst_s = 1'b1; rst_b = 1'b1; sel = 1'b0;
        in_valid = 1'b0; in_sample = '0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_pad();
        test_random_stall();
        test_reset_midframe();
        test_long();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
